inert_seq: RTL and testbench

- Command sequencer sitting directly upstream of the 16-bit SPI master in the Segway sensing path.
- After power-up it waits for the IMU to boot, then issues a fixed 4-word configuration write sequence.
- Each IMU data-ready interrupt (INT) triggers a 4-transaction burst that reads pitch-rate and Z-accel bytes.
- It assembles both values into 16-bit words and presents them to the downstream inertial integrator with a one-cycle valid pulse.

---
 rtl/inert_seq.sv | 218 +++++++++++++++++++++
 tb/tb_inert_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inert_seq.sv
// IMU command sequencer: boot wait, config writes, INT-driven reads.
// INERT_FAST_SIM_EN shortens the boot wait to 512 clks for simulation.
module inert_seq #(
  parameter int BOOT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld,
  output logic        init_done
);

  typedef enum logic [2:0] {
    BOOT,
    CFG,
    CFG_WT,
    IDLE,
    RD,
    RD_WT
  } state_t;

  state_t state_q, state_d;

  logic [BOOT_W-1:0] timer_q, timer_d;
  logic [1:0]  idx_q, idx_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] ptch_q, ptch_d;
  logic [15:0] az_q, az_d;
  logic        vld_q, vld_d;
  logic        init_q, init_d;
  logic        pend_q, pend_d;
  logic [7:0]  p_lo_q, p_lo_d;
  logic [7:0]  p_hi_q, p_hi_d;
  logic [7:0]  a_lo_q, a_lo_d;
  logic        int_ff1_q, int_ff2_q, int_ff3_q;

  logic        int_rise;
  logic        boot_end;
  logic        done_ok;
  logic        unused_hi;

  assign unused_hi = ^rd_data[15:8];
  assign int_rise  = int_ff2_q & ~int_ff3_q;
  // done still reflects the previous transfer in the wrt cycle
  assign done_ok   = done & ~wrt_q;

`ifdef INERT_FAST_SIM_EN
  assign boot_end = &timer_q[8:0];
`else
  assign boot_end = &timer_q;
`endif

  function automatic logic [15:0] cfg_cmd(input logic [1:0] i);
    logic [15:0] c;
    unique case (i)
      2'd0: c = 16'h0D02;
      2'd1: c = 16'h1053;
      2'd2: c = 16'h1150;
      2'd3: c = 16'h1460;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic [15:0] rd_cmd(input logic [1:0] i);
    logic [15:0] c;
    unique case (i)
      2'd0: c = 16'hA200;
      2'd1: c = 16'hA300;
      2'd2: c = 16'hAC00;
      2'd3: c = 16'hAD00;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  // INT synchronizer plus edge-detect stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      int_ff3_q <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      int_ff3_q <= int_ff2_q;
    end
  end

  // sequencer state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      timer_q <= '0;
      idx_q   <= 2'd0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      ptch_q  <= 16'h0000;
      az_q    <= 16'h0000;
      vld_q   <= 1'b0;
      init_q  <= 1'b0;
      pend_q  <= 1'b0;
      p_lo_q  <= 8'h00;
      p_hi_q  <= 8'h00;
      a_lo_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      ptch_q  <= ptch_d;
      az_q    <= az_d;
      vld_q   <= vld_d;
      init_q  <= init_d;
      pend_q  <= pend_d;
      p_lo_q  <= p_lo_d;
      p_hi_q  <= p_hi_d;
      a_lo_q  <= a_lo_d;
    end
  end

  // next-state, command issue and byte assembly
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    ptch_d  = ptch_q;
    az_d    = az_q;
    vld_d   = 1'b0;
    init_d  = init_q;
    pend_d  = pend_q;
    p_lo_d  = p_lo_q;
    p_hi_d  = p_hi_q;
    a_lo_d  = a_lo_q;
    unique case (state_q)
      BOOT: begin
        timer_d = timer_q + 1'b1;
        if (boot_end) begin
          wrt_d   = 1'b1;
          cmd_d   = cfg_cmd(2'd0);
          idx_d   = 2'd0;
          state_d = CFG_WT;
        end
      end
      CFG: begin
        wrt_d   = 1'b1;
        cmd_d   = cfg_cmd(idx_q);
        state_d = CFG_WT;
      end
      CFG_WT: begin
        if (done_ok) begin
          if (idx_q == 2'd3) begin
            init_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = CFG;
          end
        end
      end
      IDLE: begin
        if (pend_q | int_rise) begin
          // a fresh edge while pend drains re-arms pend
          pend_d  = pend_q & int_rise;
          idx_d   = 2'd0;
          state_d = RD;
        end
      end
      RD: begin
        if (int_rise) pend_d = 1'b1;
        wrt_d   = 1'b1;
        cmd_d   = rd_cmd(idx_q);
        state_d = RD_WT;
      end
      RD_WT: begin
        if (int_rise) pend_d = 1'b1;
        if (done_ok) begin
          unique case (1'b1)
            idx_q == 2'd0: p_lo_d = rd_data[7:0];
            idx_q == 2'd1: p_hi_d = rd_data[7:0];
            idx_q == 2'd2: a_lo_d = rd_data[7:0];
            idx_q == 2'd3: begin
              ptch_d = {p_hi_q, p_lo_q};
              az_d   = {rd_data[7:0], a_lo_q};
              vld_d  = 1'b1;
            end
            default: ;
          endcase
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = RD;
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign ptch_rt   = ptch_q;
  assign AZ        = az_q;
  assign vld       = vld_q;
  assign init_done = init_q;

endmodule

// File: tb/tb_inert_seq.sv
// Scoreboard bench for inert_seq with a 40-clk SPI master model.
// Runs with BOOT_W=9 so both builds end the boot wait at 511.
module tb_inert_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        INT;
  logic        done;
  logic [15:0] rd_data;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;
  logic        init_done;

  inert_seq #(.BOOT_W(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .INT       (INT),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .cmd       (cmd),
    .ptch_rt   (ptch_rt),
    .AZ        (AZ),
    .vld       (vld),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wrt   = 0;
  int n_vld   = 0;
  int cyc     = 0;
  int first_wrt = -1;
  int cnt     = 0;
  logic prev_wrt = 1'b0;
  logic prev_vld = 1'b0;

  logic [7:0] pl, ph, al, ah;

  logic [15:0] exp_cmd[$];
  logic [31:0] exp_out[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [15:0] c);
    logic [7:0] b;
    case (c[15:8])
      8'hA2:   b = pl;
      8'hA3:   b = ph;
      8'hAC:   b = al;
      8'hAD:   b = ah;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // SPI master model: done low for 40 clks after each wrt
  always @(negedge clk) begin
    if (!rst_n) begin
      done = 1'b1;
      cnt  = 0;
    end else if (wrt) begin
      done    = 1'b0;
      cnt     = 40;
      rd_data = {8'hA5, model_byte(cmd)};
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) done = 1'b1;
    end
  end

  // monitor: pops scoreboard on wrt and vld
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cyc       = 0;
      first_wrt = -1;
      prev_wrt  = 1'b0;
      prev_vld  = 1'b0;
    end else begin
      cyc++;
      if (wrt) begin
        n_wrt++;
        if (first_wrt < 0) first_wrt = cyc;
        check("wrt_width", {31'd0, prev_wrt}, 32'd0);
        check("wrt_done_hi", {31'd0, done}, 32'd1);
        if (exp_cmd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL cmd_unexp: got %0h want none", cmd);
        end else begin
          check("cmd", {16'd0, cmd},
                {16'd0, exp_cmd.pop_front()});
        end
      end
      if (vld) begin
        n_vld++;
        check("vld_width", {31'd0, prev_vld}, 32'd0);
        if (exp_out.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL vld_unexp: got %0h_%0h want none",
                   ptch_rt, AZ);
        end else begin
          check("ptch_az", {ptch_rt, AZ}, exp_out.pop_front());
        end
      end
      prev_wrt = wrt;
      prev_vld = vld;
    end
  end

  task automatic push_cfg();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1053);
    exp_cmd.push_back(16'h1150);
    exp_cmd.push_back(16'h1460);
  endtask

  task automatic push_rd();
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    exp_cmd.push_back(16'hAD00);
  endtask

  task automatic pulse_int(input int n);
    INT = 1'b1;
    repeat (n) @(negedge clk);
    INT = 1'b0;
  endtask

  task automatic wait_wrt(input int tgt, input string nm);
    for (int i = 0; i < 3000 && n_wrt < tgt; i++)
      @(negedge clk);
    check(nm, {31'd0, n_wrt >= tgt}, 32'd1);
  endtask

  task automatic wait_vld(input int tgt, input string nm);
    for (int i = 0; i < 3000 && n_vld < tgt; i++)
      @(negedge clk);
    check(nm, {31'd0, n_vld >= tgt}, 32'd1);
  endtask

  task automatic wait_init(input string nm);
    for (int i = 0; i < 3000 && !init_done; i++)
      @(negedge clk);
    check(nm, {31'd0, init_done}, 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_wrt"},  {31'd0, wrt}, 32'd0);
    check({tag, "_cmd"},  {16'd0, cmd}, 32'd0);
    check({tag, "_ptch"}, {16'd0, ptch_rt}, 32'd0);
    check({tag, "_az"},   {16'd0, AZ}, 32'd0);
    check({tag, "_vld"},  {31'd0, vld}, 32'd0);
    check({tag, "_init"}, {31'd0, init_done}, 32'd0);
  endtask

  initial begin
    int bw, bv;
    rst_n   = 1'b0;
    INT     = 1'b0;
    done    = 1'b1;
    rd_data = 16'h0000;
    pl = 8'h00; ph = 8'h00; al = 8'h00; ah = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");

    // boot wait and config; INT during config is ignored
    push_cfg();
    rst_n = 1'b1;
    wait_wrt(2, "cfg_wrt2");
    pulse_int(10);
    repeat (5) @(negedge clk);
    check("cfg_pend", {31'd0, dut.pend_q}, 32'd0);
    wait_init("init1");
    check("first_wrt", first_wrt, 32'd512);
    check("cfg_nwrt", n_wrt, 32'd4);
    check("cfg_nvld", n_vld, 32'd0);
    repeat (10) @(negedge clk);
    check("idle_pend", {31'd0, dut.pend_q}, 32'd0);

    // single burst
    pl = 8'h34; ph = 8'h12; al = 8'h78; ah = 8'h56;
    push_rd();
    exp_out.push_back({16'h1234, 16'h5678});
    pulse_int(10);
    wait_vld(1, "burst1_vld");
    repeat (5) @(negedge clk);
    check("burst1_q", exp_cmd.size(), 32'd0);

    // two INTs after 2nd wrt collapse into one extra burst
    pl = 8'hCD; ph = 8'hAB; al = 8'h01; ah = 8'hEF;
    push_rd();
    push_rd();
    exp_out.push_back({16'hABCD, 16'hEF01});
    exp_out.push_back({16'hABCD, 16'hEF01});
    bw = n_wrt;
    bv = n_vld;
    pulse_int(3);
    wait_wrt(bw + 2, "burst2_wrt2");
    repeat (3) @(negedge clk);
    pulse_int(3);
    repeat (4) @(negedge clk);
    pulse_int(3);
    wait_vld(bv + 2, "burst2_vld");
    repeat (300) @(negedge clk);
    check("burst2_nvld", n_vld, bv + 2);
    check("burst2_qc", exp_cmd.size(), 32'd0);
    check("burst2_qo", exp_out.size(), 32'd0);

    // reset in RD_WT of idx2
    pl = 8'h11; ph = 8'h22; al = 8'h33; ah = 8'h44;
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    bw = n_wrt;
    bv = n_vld;
    pulse_int(4);
    wait_wrt(bw + 3, "rst_wrt3");
    repeat (10) @(negedge clk);
    check("rst_idx2", {30'd0, dut.idx_q}, 32'd2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outs("mid");
    check("mid_q", exp_cmd.size(), 32'd0);
    push_cfg();
    rst_n = 1'b1;
    wait_init("init2");
    check("first_wrt2", first_wrt, 32'd512);
    check("rst_nvld", n_vld, bv);
    check("rst_ptch", {16'd0, ptch_rt}, 32'd0);
    check("rst_az", {16'd0, AZ}, 32'd0);
    check("rst_qc", exp_cmd.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
